// File: rtl/eq_pkg.sv
// Shared constants, band edge table, register map and FSM state type for the
// FFT-domain equalizer band scheduler.
package eq_pkg;

    localparam int NUM_BANDS = 12;
    localparam int BIN_W     = 14;
    localparam int FRAME_LEN = 4096;
    localparam int GAIN_W    = 5;
    localparam int UNITY     = 13;

    // Exclusive upper bin of each band; band k covers [edge[k-1], edge[k]).
    localparam logic [BIN_W-1:0] BAND_EDGE [NUM_BANDS] = '{
        14'd10,  14'd20,  14'd37,   14'd64,   14'd100,  14'd151,
        14'd325, 14'd696, 14'd1208, 14'd2043, 14'd3158, 14'd4096
    };

    localparam logic [3:0] ADDR_CTRL   = 4'd12;
    localparam logic [3:0] ADDR_STATUS = 4'd13;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
    typedef logic [GAIN_W-1:0] gain_t;

endpackage

// File: rtl/eq_band_lookup.sv
// Combinational bin-to-band priority compare against the band edge table.
module eq_band_lookup
    import eq_pkg::*;
(
    input  logic [BIN_W-1:0] bin,
    output logic [3:0]       band,
    output logic             hit
);

    // Scan from the top edge down so the lowest matching edge wins.
    always_comb begin
        band = 4'd11;
        hit  = 1'b0;
        for (int unsigned k = NUM_BANDS; k > 0; k--) begin
            if (bin < BAND_EDGE[k-1]) begin
                band = 4'(k - 1);
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eq_band_scheduler.sv
// Frame/bin tracker emitting per-bin band and shift exponent, with
// double-buffered band gains behind an Avalon-MM register slave.
module eq_band_scheduler
    import eq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    input  logic             s_sop,
    input  logic             s_eop,
    input  logic             m_ready,
    output logic             s_ready,
    output logic             ctl_valid,
    output logic             ctl_sop,
    output logic             ctl_eop,
    output logic [BIN_W-1:0] ctl_bin,
    output logic [3:0]       ctl_band,
    output logic [6:0]       ctl_exp,
    input  logic [3:0]       address,
    input  logic [7:0]       writedata,
    output logic [7:0]       readdata,
    input  logic             chipselect,
    input  logic             write,
    input  logic             read
);

    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(FRAME_LEN - 1);
    localparam logic [BIN_W-1:0] BIN_OVF  = BIN_W'(FRAME_LEN);

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             pending_q, pending_d;
    logic             err_q, err_d;
    gain_t            staged_q [NUM_BANDS];
    gain_t            staged_d [NUM_BANDS];
    gain_t            active_q [NUM_BANDS];
    gain_t            active_d [NUM_BANDS];
    logic             ctl_valid_q, ctl_valid_d;
    logic             ctl_sop_q, ctl_sop_d;
    logic             ctl_eop_q, ctl_eop_d;
    logic [BIN_W-1:0] ctl_bin_q, ctl_bin_d;
    logic [3:0]       ctl_band_q, ctl_band_d;
    logic [6:0]       ctl_exp_q, ctl_exp_d;
    logic [7:0]       readdata_q, readdata_d;

    logic             beat;
    logic             commit_now;
    logic [BIN_W-1:0] cur_bin;
    logic [3:0]       band;
    logic             band_hit;
    gain_t            gain_sel;
    logic             unity_out;
    logic             err_set;
    logic             err_clr;
    logic             ctrl_set;

    assign s_ready    = m_ready;
    assign beat       = s_valid && m_ready;
    assign commit_now = pending_q && ((state_q == ST_IDLE && !beat) || (beat && s_sop));

    // Bin of the current beat; an overrun bin (internal marker FRAME_LEN) reports as the last bin.
    always_comb begin
        cur_bin = bin_q;
        if (state_q == ST_IDLE || s_sop) begin
            cur_bin = '0;
        end else if (bin_q == BIN_OVF) begin
            cur_bin = BIN_LAST;
        end
    end

    eq_band_lookup u_lookup (
        .bin  (cur_bin),
        .band (band),
        .hit  (band_hit)
    );

    // A sop beat that commits already sees the staged gains.
    assign gain_sel = commit_now ? staged_q[band] : active_q[band];

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        pending_d   = pending_q;
        staged_d    = staged_q;
        active_d    = active_q;
        readdata_d  = readdata_q;
        ctl_valid_d = 1'b0;
        ctl_sop_d   = ctl_sop_q;
        ctl_eop_d   = ctl_eop_q;
        ctl_bin_d   = ctl_bin_q;
        ctl_band_d  = ctl_band_q;
        ctl_exp_d   = ctl_exp_q;
        unity_out   = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        ctrl_set    = 1'b0;

        if (beat) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!s_sop) begin
                        unity_out = 1'b1;
                        err_set   = 1'b1;
                    end else if (s_eop) begin
                        err_set = 1'b1;
                    end else begin
                        state_d = ST_ACTIVE;
                        bin_d   = BIN_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (s_sop) begin
                        err_set = 1'b1;
                        bin_d   = BIN_W'(1);
                    end else if (bin_q == BIN_OVF) begin
                        if (!s_eop) begin
                            unity_out = 1'b1;
                            err_set   = 1'b1;
                        end
                    end else begin
                        bin_d = bin_q + BIN_W'(1);
                    end
                    if (s_eop) begin
                        state_d = ST_IDLE;
                        bin_d   = '0;
                        if (cur_bin != BIN_LAST) begin
                            err_set = 1'b1;
                        end
                    end
                end
            endcase
            ctl_valid_d = 1'b1;
            ctl_sop_d   = s_sop;
            ctl_eop_d   = s_eop;
            ctl_bin_d   = cur_bin;
            ctl_band_d  = band;
            ctl_exp_d   = (unity_out || !band_hit) ? '0 : 7'(UNITY) - {2'b00, gain_sel};
        end

        if (chipselect && write) begin
            if (address < ADDR_CTRL) begin
                staged_d[address] = writedata[GAIN_W-1:0];
            end else if (address == ADDR_CTRL) begin
                ctrl_set = writedata[0];
            end else if (address == ADDR_STATUS) begin
                err_clr = writedata[2];
            end
        end else if (chipselect && read) begin
            if (address < ADDR_CTRL) begin
                readdata_d = {3'b000, staged_q[address]};
            end else if (address == ADDR_CTRL) begin
                readdata_d = {7'b0, pending_q};
            end else if (address == ADDR_STATUS) begin
                readdata_d = {5'b0, err_q, state_q == ST_ACTIVE, pending_q};
            end else begin
                readdata_d = '0;
            end
        end

        // A commit request landing on a commit opportunity waits for the next one.
        if (commit_now) begin
            active_d  = staged_q;
            pending_d = 1'b0;
        end
        if (ctrl_set) begin
            pending_d = 1'b1;
        end
        err_d = (err_q && !err_clr) || err_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                staged_q[i] <= GAIN_W'(UNITY);
                active_q[i] <= GAIN_W'(UNITY);
            end
            ctl_valid_q <= 1'b0;
            ctl_sop_q   <= 1'b0;
            ctl_eop_q   <= 1'b0;
            ctl_bin_q   <= '0;
            ctl_band_q  <= '0;
            ctl_exp_q   <= '0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            staged_q    <= staged_d;
            active_q    <= active_d;
            ctl_valid_q <= ctl_valid_d;
            ctl_sop_q   <= ctl_sop_d;
            ctl_eop_q   <= ctl_eop_d;
            ctl_bin_q   <= ctl_bin_d;
            ctl_band_q  <= ctl_band_d;
            ctl_exp_q   <= ctl_exp_d;
            readdata_q  <= readdata_d;
        end
    end

    assign ctl_valid = ctl_valid_q;
    assign ctl_sop   = ctl_sop_q;
    assign ctl_eop   = ctl_eop_q;
    assign ctl_bin   = ctl_bin_q;
    assign ctl_band  = ctl_band_q;
    assign ctl_exp   = ctl_exp_q;
    assign readdata  = readdata_q;

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Directed bench for eq_band_scheduler: register table vectors plus
// hand-written frame sequences with a small band/gain reference model.
module tb_eq_band_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid, s_sop, s_eop, m_ready, s_ready;
    logic        ctl_valid, ctl_sop, ctl_eop;
    logic [13:0] ctl_bin;
    logic [3:0]  ctl_band;
    logic [6:0]  ctl_exp;
    logic [3:0]  address;
    logic [7:0]  writedata, readdata;
    logic        chipselect, write, read;

    eq_band_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_sop      (s_sop),
        .s_eop      (s_eop),
        .m_ready    (m_ready),
        .s_ready    (s_ready),
        .ctl_valid  (ctl_valid),
        .ctl_sop    (ctl_sop),
        .ctl_eop    (ctl_eop),
        .ctl_bin    (ctl_bin),
        .ctl_band   (ctl_band),
        .ctl_exp    (ctl_exp),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .chipselect (chipselect),
        .write      (write),
        .read       (read)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    typedef struct {
        int         at;
        logic       wr;
        logic       rd;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } bus_op_t;

    int      n_cmp = 0;
    int      n_bad = 0;
    int      edges [12] = '{10, 20, 37, 64, 100, 151, 325, 696, 1208, 2043, 3158, 4096};
    int      exp_gain [12];
    vec_t    vecs [$];
    bus_op_t fops [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_band(input int b);
        for (int k = 0; k < 12; k++) begin
            if (b < edges[k]) return k;
        end
        return 11;
    endfunction

    task automatic check_beat(input int bin, input logic sop, input logic eop, input logic unity);
        int b;
        int e;
        b = ref_band(bin);
        e = unity ? 0 : 13 - exp_gain[b];
        check($sformatf("beat bin %0d", bin),
              {ctl_valid, ctl_sop, ctl_eop, ctl_bin, ctl_band, ctl_exp},
              {1'b1, sop, eop, 14'(bin), 4'(b), 7'(e)});
    endtask

    task automatic bus_op(input logic wr, input logic rd, input logic [3:0] a, input logic [7:0] d);
        chipselect = 1'b1;
        write      = wr;
        read       = rd;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        bus_op(1'b0, 1'b1, a, 8'h00);
        check(name, readdata, exp);
    endtask

    // Streams one frame of n back-to-back beats, optionally stalling m_ready
    // for three cycles before beat stall_at and issuing the queued bus ops.
    task automatic run_frame(input int n, input int stall_at);
        logic       rd_chk;
        logic [7:0] rd_exp;
        for (int i = 0; i < n; i++) begin
            rd_chk = 1'b0;
            rd_exp = '0;
            if (i == stall_at) begin
                s_valid = 1'b1;
                s_sop   = 1'b0;
                s_eop   = 1'b0;
                m_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check("stall s_ready", s_ready, 0);
                    check("stall ctl_valid", ctl_valid, 0);
                end
                m_ready = 1'b1;
            end
            s_valid = 1'b1;
            s_sop   = (i == 0);
            s_eop   = (i == n - 1);
            foreach (fops[j]) begin
                if (fops[j].at == i) begin
                    chipselect = 1'b1;
                    write      = fops[j].wr;
                    read       = fops[j].rd;
                    address    = fops[j].addr;
                    writedata  = fops[j].wdata;
                    rd_chk     = fops[j].rd;
                    rd_exp     = fops[j].exp_rd;
                end
            end
            tick();
            chipselect = 1'b0;
            write      = 1'b0;
            read       = 1'b0;
            check_beat(i, i == 0, i == n - 1, 1'b0);
            if (rd_chk) check($sformatf("frame read bin %0d", i), readdata, rd_exp);
        end
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        fops.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int g = 0; g < 12; g++) exp_gain[g] = 13;

        for (int a = 0; a < 12; a++) vecs.push_back('{1'b0, 1'b1, 4'(a), 8'h00, 8'd13});
        vecs.push_back('{1'b0, 1'b1, 4'd12, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 4'd13, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 4'd15, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 4'd14, 8'hFF, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 4'd14, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 4'd5,  8'h00, 8'd13});
        vecs.push_back('{1'b1, 1'b0, 4'd5,  8'hFF, 8'd13});
        vecs.push_back('{1'b1, 1'b1, 4'd5,  8'h0D, 8'd13});
        vecs.push_back('{1'b0, 1'b1, 4'd5,  8'h00, 8'd13});

        reset      = 1'b1;
        s_valid    = 1'b0;
        s_sop      = 1'b0;
        s_eop      = 1'b0;
        m_ready    = 1'b1;
        address    = '0;
        writedata  = '0;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset ctl/readdata", {ctl_valid, ctl_sop, ctl_eop, ctl_bin, ctl_band, ctl_exp, readdata}, 0);
        check("reset s_ready", s_ready, 1);

        foreach (vecs[v]) begin
            bus_op(vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].wdata);
            check($sformatf("reg vec %0d addr %0d", v, vecs[v].addr), readdata, vecs[v].exp_rd);
        end

        // Unity frame.
        run_frame(4096, -1);
        read_check("status after unity frame", 4'd13, 8'h00);

        // Gain 20 on band 3, commit from idle.
        bus_op(1'b1, 1'b0, 4'd3, 8'd20);
        bus_op(1'b1, 1'b0, 4'd12, 8'h01);
        read_check("status pending before idle commit", 4'd13, 8'h01);
        read_check("status after idle commit", 4'd13, 8'h00);
        exp_gain[3] = 20;
        run_frame(4096, -1);
        read_check("status after band3 frame", 4'd13, 8'h00);

        // Commit requested mid-frame applies at the next sop.
        bus_op(1'b1, 1'b0, 4'd0, 8'd5);
        fops.push_back('{100, 1'b1, 1'b0, 4'd12, 8'h01, 8'h00});
        fops.push_back('{200, 1'b0, 1'b1, 4'd13, 8'h00, 8'h03});
        run_frame(4096, -1);
        exp_gain[0] = 5;
        fops.push_back('{1, 1'b0, 1'b1, 4'd13, 8'h00, 8'h02});
        run_frame(4096, 1000);
        read_check("status after mid-frame commit", 4'd13, 8'h00);

        // Early eop sets sticky err; software clears it.
        run_frame(2001, -1);
        read_check("status after short frame", 4'd13, 8'h04);
        bus_op(1'b1, 1'b0, 4'd13, 8'h04);
        read_check("status after err clear", 4'd13, 8'h00);

        // Stray beat in idle, then a sop arriving mid-frame.
        s_valid = 1'b1;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        tick();
        check_beat(0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_sop   = (i == 0);
            s_eop   = 1'b0;
            tick();
            check_beat(i, i == 0, 1'b0, 1'b0);
        end
        run_frame(4096, -1);
        read_check("status after stray and restart", 4'd13, 8'h04);
        bus_op(1'b1, 1'b0, 4'd13, 8'h04);
        read_check("status final clear", 4'd13, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
